unprojection: RTL

UNPROJECTION -- requirements
Module: unprojection

---
 rtl/unprojection.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/unprojection.sv
// ============================================================================
// unprojection: recovers world X/Y from projected screen X/Y and depth z.
// Revision: 1.0
// ============================================================================
`default_nettype none

module unprojection #(
   parameter int VANISHING_PNT = -10,
   parameter int Z_DISTANCE    = 0,
   parameter int PRECISION     = 0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [15:0] sx,
   input  logic signed [15:0] sy,
   input  logic signed [15:0] z,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [33:0] wx,
   output logic signed [33:0] wy
);

   localparam int SCALE = (PRECISION == 0) ? 1    :
                          (PRECISION == 1) ? 10   :
                          (PRECISION == 2) ? 100  :
                          (PRECISION == 3) ? 1000 : 10000;
   localparam longint C_K = longint'(SCALE) * longint'(VANISHING_PNT);
   localparam logic [33:0] C_KMAG = 34'((C_K < 0) ? -C_K : C_K);
   localparam logic C_KNEG = (C_K < 0);
   localparam logic signed [17:0] C_DOFF = 18'(Z_DISTANCE + VANISHING_PNT);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      DIVX = 3'd2,
      DIVY = 3'd3,
      SIGN = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t state, state_nx;

   logic signed [15:0] sx_q, sy_q;
   logic signed [17:0] d_q;
   logic [32:0] magy_q;
   logic        sgnx_q, sgny_q;
   logic [32:0] num_q, qx_q;
   logic [33:0] rem_q;
   logic [5:0]  cnt_q;

   logic               accept, last_bit;
   logic signed [33:0] px, py;
   logic [34:0]        shifted;
   logic               qbit;
   logic [33:0]        rem_nx;
   logic [32:0]        num_nx;

   assign accept   = in_valid && (state == IDLE);
   assign last_bit = (cnt_q == 6'd32);

   assign px = 34'(sx_q) * 34'(d_q);
   assign py = 34'(sy_q) * 34'(d_q);

   // One restoring step: remainder stays below |K|, so 34 bits always hold it.
   assign shifted = {rem_q, num_q[32]};
   assign qbit    = (shifted >= {1'b0, C_KMAG});
   assign rem_nx  = qbit ? 34'(shifted - {1'b0, C_KMAG}) : shifted[33:0];
   assign num_nx  = {num_q[31:0], qbit};

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = MUL;
         end
         MUL:  state_nx = DIVX;
         DIVX: if (last_bit) state_nx = DIVY;
         DIVY: if (last_bit) state_nx = SIGN;
         SIGN: state_nx = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sx_q   <= '0;
         sy_q   <= '0;
         d_q    <= '0;
         magy_q <= '0;
         sgnx_q <= 1'b0;
         sgny_q <= 1'b0;
         num_q  <= '0;
         qx_q   <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         wx     <= '0;
         wy     <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               sx_q <= sx;
               sy_q <= sy;
               d_q  <= 18'(z) + C_DOFF;
            end
            MUL: begin
               num_q  <= 33'(px[33] ? -px : px);
               magy_q <= 33'(py[33] ? -py : py);
               sgnx_q <= px[33] ^ C_KNEG;
               sgny_q <= py[33] ^ C_KNEG;
               rem_q  <= '0;
               cnt_q  <= '0;
            end
            DIVX: begin
               cnt_q <= last_bit ? 6'd0 : cnt_q + 6'd1;
               if (last_bit) begin
                  qx_q  <= num_nx;
                  num_q <= magy_q;
                  rem_q <= '0;
               end else begin
                  num_q <= num_nx;
                  rem_q <= rem_nx;
               end
            end
            DIVY: begin
               cnt_q <= last_bit ? 6'd0 : cnt_q + 6'd1;
               num_q <= num_nx;
               rem_q <= rem_nx;
            end
            SIGN: begin
               wx <= sgnx_q ? -{1'b0, qx_q}  : {1'b0, qx_q};
               wy <= sgny_q ? -{1'b0, num_q} : {1'b0, num_q};
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
